// File: rtl/gmem_axi_pkg.sv
// Shared types and helpers for the gmem m_axi read-path blocks.
package gmem_axi_pkg;

  localparam int unsigned NUM_PORTS_DEF   = 4;
  localparam int unsigned ID_WIDTH_DEF    = 2;
  localparam int unsigned ORDER_DEPTH_DEF = 16;

  // Upper bounds the round-robin helper is sized for.
  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned MAX_ID_W  = 3;

  typedef logic [ID_WIDTH_DEF-1:0] port_idx_t;

  typedef enum logic {
    REQ_EMPTY = 1'b0,
    REQ_FULL  = 1'b1
  } req_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // First requester after 'last', scanning last+1, last+2, ... modulo num_ports.
  function automatic rr_pick_t rr_next(input logic [MAX_PORTS-1:0] req,
                                       input logic [MAX_ID_W-1:0]  last,
                                       input int unsigned          num_ports);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
      cand = (32'(last) + k) % num_ports;
      if (k <= num_ports && !pick.found && req[cand[MAX_ID_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = MAX_ID_W'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gmem_m_axi_order_fifo.sv
// Grant-order FIFO: holds the port index of every outstanding read burst.
module gmem_m_axi_order_fifo
  import gmem_axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = ID_WIDTH_DEF,
  parameter int unsigned ORDER_DEPTH = ORDER_DEPTH_DEF,
  parameter int unsigned ORDER_AW    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [ID_WIDTH-1:0] push_id,
  input  logic                pop,
  output logic [ID_WIDTH-1:0] head,
  output logic                empty,
  output logic                full,
  output logic [ORDER_AW:0]   count
);

  logic [ID_WIDTH-1:0] mem_q [ORDER_DEPTH];
  logic [ORDER_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ORDER_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ORDER_AW:0]   count_q,  count_d;

  // Pointers wrap naturally because ORDER_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ORDER_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ORDER_AW'(1);
    count_d = count_q + (ORDER_AW+1)'(push) - (ORDER_AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_id;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (ORDER_AW+1)'(ORDER_DEPTH));
  assign count = count_q;

endmodule

// File: rtl/gmem_m_axi_rd_arbiter.sv
// Round-robin arbiter for the gmem read-request channel with in-order
// steering of returning read bursts back to their requesters.
module gmem_m_axi_rd_arbiter
  import gmem_axi_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = NUM_PORTS_DEF,
  parameter int unsigned ID_WIDTH    = ID_WIDTH_DEF,
  parameter int unsigned REQ_WIDTH   = 96,
  parameter int unsigned RSP_WIDTH   = 64,
  parameter int unsigned ORDER_DEPTH = ORDER_DEPTH_DEF,
  parameter int unsigned ORDER_AW    = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PORTS*REQ_WIDTH-1:0] s_req_data,
  input  logic [NUM_PORTS-1:0]           s_req_valid,
  output logic [NUM_PORTS-1:0]           s_req_ready,
  output logic [REQ_WIDTH-1:0]           m_req_data,
  output logic [ID_WIDTH-1:0]            m_req_id,
  output logic                           m_req_valid,
  input  logic                           m_req_ready,
  input  logic [RSP_WIDTH-1:0]           s_rsp_data,
  input  logic                           s_rsp_last,
  input  logic                           s_rsp_valid,
  output logic                           s_rsp_ready,
  output logic [RSP_WIDTH-1:0]           m_rsp_data,
  output logic                           m_rsp_last,
  output logic [NUM_PORTS-1:0]           m_rsp_valid,
  input  logic [NUM_PORTS-1:0]           m_rsp_ready,
  output logic [ORDER_AW:0]              outstanding
);

  req_state_e           state_q, state_d;
  logic [ID_WIDTH-1:0]  last_grant_q, last_grant_d;
  logic [REQ_WIDTH-1:0] m_req_data_q, m_req_data_d;
  logic [ID_WIDTH-1:0]  m_req_id_q,   m_req_id_d;

  logic                 fifo_empty, fifo_full, fifo_pop;
  logic [ID_WIDTH-1:0]  fifo_head;
  logic                 can_load, grant;
  rr_pick_t             pick;

  // Arbitration and request output register next-state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_req_data_d = m_req_data_q;
    m_req_id_d   = m_req_id_q;
    s_req_ready  = '0;

    can_load = ((state_q == REQ_EMPTY) || m_req_ready) && !fifo_full;
    pick     = rr_next(MAX_PORTS'(s_req_valid), MAX_ID_W'(last_grant_q), NUM_PORTS);
    grant    = can_load && pick.found;

    if (grant) begin
      s_req_ready  = NUM_PORTS'(1) << pick.idx;
      state_d      = REQ_FULL;
      last_grant_d = ID_WIDTH'(pick.idx);
      m_req_id_d   = ID_WIDTH'(pick.idx);
      m_req_data_d = s_req_data[32'(pick.idx)*REQ_WIDTH +: REQ_WIDTH];
    end else if ((state_q == REQ_FULL) && m_req_ready) begin
      state_d = REQ_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= REQ_EMPTY;
      last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Payload and id carry no reset; m_req_valid qualifies them.
  always_ff @(posedge clk) begin
    m_req_data_q <= m_req_data_d;
    m_req_id_q   <= m_req_id_d;
  end

  assign m_req_valid = (state_q == REQ_FULL);
  assign m_req_data  = m_req_data_q;
  assign m_req_id    = m_req_id_q;

  // Zero-latency steering of read beats to the oldest outstanding requester.
  always_comb begin
    m_rsp_valid = '0;
    s_rsp_ready = 1'b0;
    if (!fifo_empty) begin
      s_rsp_ready = m_rsp_ready[fifo_head];
      if (s_rsp_valid) m_rsp_valid = NUM_PORTS'(1) << fifo_head;
    end
    fifo_pop = s_rsp_valid && s_rsp_ready && s_rsp_last;
  end

  assign m_rsp_data = s_rsp_data;
  assign m_rsp_last = s_rsp_last;

  gmem_m_axi_order_fifo #(
    .ID_WIDTH    (ID_WIDTH),
    .ORDER_DEPTH (ORDER_DEPTH),
    .ORDER_AW    (ORDER_AW)
  ) u_order_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (grant),
    .push_id (ID_WIDTH'(pick.idx)),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (outstanding)
  );

endmodule
